// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared types and constants for the divider sequencer and the
//               HI/LO register file.
//               - div_state_e : sequencer state (IDLE, RUN, ABORT), 2 bits
//               - DIV_LAT     : iterative divider latency in cycles
// Revision    : 1.0  initial release
// ============================================================================
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ABORT = 2'd2
    } div_state_e;

    localparam int DIV_LAT = 33;

endpackage
`default_nettype wire

// File: rtl/div_hilo_ctrl_hilo_regfile.sv
`default_nettype none
// ============================================================================
// Module      : hilo_regfile
// Description : HI/LO architectural registers with write mux and read bypass.
//               A divider capture takes priority over MTHI/MTLO. The read
//               ports show the value that will be in the register after the
//               next edge.
// Ports       : clk, resetn         clock, synchronous active-low reset
//               cap_we              capture divider result this cycle
//               cap_hi, cap_lo      remainder / quotient to capture
//               hi_we, lo_we        MTHI / MTLO write enables (already gated)
//               wdata               MTHI / MTLO data
//               hi_rdata, lo_rdata  bypassed read data
// Revision    : 1.0  initial release
// ============================================================================
module hilo_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cap_we,
    input  logic [DATA_W-1:0] cap_hi,
    input  logic [DATA_W-1:0] cap_lo,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (cap_we) begin
            r_hi <= cap_hi;
            r_lo <= cap_lo;
        end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

    // Same priority as the write mux so a read never sees a stale value.
    always_comb begin
        hi_rdata = r_hi;
        lo_rdata = r_lo;
        if (cap_we) begin
            hi_rdata = cap_hi;
            lo_rdata = cap_lo;
        end else begin
            if (hi_we) hi_rdata = wdata;
            if (lo_we) lo_rdata = wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_hilo_ctrl
// Description : Sequencer between EX and the 33-cycle iterative divider.
//               Latches DIV/DIVU operands, holds dv_div high until the
//               divider completes, captures quotient/remainder into LO/HI and
//               stalls the pipeline meanwhile. A flush or a timeout aborts the
//               divide through a one-cycle dv_choke. Owns the HI/LO registers.
// Ports       : div_clk, resetn            clock, synchronous active-low reset
//               ex_div_valid/_signed       DIV/DIVU request from EX
//               ex_src_a, ex_src_b         dividend / divisor
//               ex_flush                   kill EX instruction / abort divide
//               mthi_we, mtlo_we, mt_data  HI/LO writes
//               hi_rdata, lo_rdata         bypassed HI/LO read data
//               stall, div_busy, div_err   pipeline control and status
//               dv_*                       divider interface
// Revision    : 1.0  initial release
// ============================================================================
module div_hilo_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic              div_clk,
    input  logic              resetn,
    input  logic              ex_div_valid,
    input  logic              ex_div_signed,
    input  logic [DATA_W-1:0] ex_src_a,
    input  logic [DATA_W-1:0] ex_src_b,
    input  logic              ex_flush,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata,
    output logic              stall,
    output logic              div_busy,
    output logic              div_err,
    output logic              dv_div,
    output logic              dv_div_signed,
    output logic [DATA_W-1:0] dv_x,
    output logic [DATA_W-1:0] dv_y,
    output logic              dv_choke,
    input  logic [DATA_W-1:0] dv_s,
    input  logic [DATA_W-1:0] dv_r,
    input  logic              dv_complete
);

    localparam int c_cnt_w = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV_TIMEOUT - 1);

    div_state_e        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic              r_signed;
    logic              r_div;
    logic              r_choke;
    logic              r_err;

    logic w_idle;
    logic w_run;
    logic w_abort;
    logic w_accept;
    logic w_capture;
    logic w_timeout;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_run     = (r_state == ST_RUN);
    assign w_abort   = (r_state == ST_ABORT);
    assign w_accept  = w_idle & ex_div_valid & ~ex_flush;
    // Flush wins over a simultaneous complete: nothing is written.
    assign w_capture = w_run & dv_complete & ~ex_flush;
    assign w_timeout = w_run & ~dv_complete & (r_cnt == c_cnt_last);

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_signed <= 1'b0;
            r_div    <= 1'b0;
            r_choke  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err   <= 1'b0;
            r_choke <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x      <= ex_src_a;
                        r_y      <= ex_src_b;
                        r_signed <= ex_div_signed;
                        r_cnt    <= '0;
                        r_div    <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ex_flush || w_timeout) begin
                        r_div   <= 1'b0;
                        r_choke <= 1'b1;
                        r_err   <= w_timeout;
                        r_state <= ST_ABORT;
                    end else if (dv_complete) begin
                        // Drop div right after complete so the divider sees it low.
                        r_div   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_div   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall         = w_accept | (w_run & ~dv_complete) | w_abort;
    assign div_busy      = ~w_idle;
    assign div_err       = r_err;
    assign dv_div        = r_div;
    assign dv_choke      = r_choke;
    assign dv_div_signed = r_signed;
    assign dv_x          = r_x;
    assign dv_y          = r_y;

    hilo_regfile #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk      (div_clk),
        .resetn   (resetn),
        .cap_we   (w_capture),
        .cap_hi   (dv_r),
        .cap_lo   (dv_s),
        .hi_we    (mthi_we & w_idle),
        .lo_we    (mtlo_we & w_idle),
        .wdata    (mt_data),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_hilo_ctrl
// Description : Self-checking bench for div_hilo_ctrl with a stub divider that
//               completes 33 cycles after div rises (or never, when disabled).
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_hilo_ctrl;

    logic        div_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_div_valid = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_src_a = '0;
    logic [31:0] ex_src_b = '0;
    logic        ex_flush = 1'b0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic [31:0] hi_rdata, lo_rdata;
    logic        stall, div_busy, div_err;
    logic        dv_div, dv_div_signed, dv_choke, dv_complete;
    logic [31:0] dv_x, dv_y, dv_s, dv_r;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 div_clk = ~div_clk;

    div_hilo_ctrl #(.DATA_W(32), .DIV_TIMEOUT(40)) dut (
        .div_clk(div_clk), .resetn(resetn),
        .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
        .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_flush(ex_flush),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
        .stall(stall), .div_busy(div_busy), .div_err(div_err),
        .dv_div(dv_div), .dv_div_signed(dv_div_signed),
        .dv_x(dv_x), .dv_y(dv_y), .dv_choke(dv_choke),
        .dv_s(dv_s), .dv_r(dv_r), .dv_complete(dv_complete)
    );

    // Stub divider: counts edges with div high, result valid in the cycle
    // after the 33rd such edge. Divide by zero yields q=all ones, r=dividend.
    int unsigned stub_cnt = 0;
    bit          stub_en = 1'b1;
    logic [31:0] stub_q, stub_r;

    always @(posedge div_clk) begin
        if (!resetn || !dv_div) stub_cnt <= 0;
        else                    stub_cnt <= stub_cnt + 1;
    end

    always_comb begin
        stub_q = '1;
        stub_r = dv_x;
        if (dv_y != 32'd0) begin
            if (dv_div_signed) begin
                stub_q = $signed(dv_x) / $signed(dv_y);
                stub_r = $signed(dv_x) % $signed(dv_y);
            end else begin
                stub_q = dv_x / dv_y;
                stub_r = dv_x % dv_y;
            end
        end
    end

    assign dv_complete = stub_en && dv_div && (stub_cnt == 33);
    assign dv_s = dv_complete ? stub_q : 32'hDEAD_BEEF;
    assign dv_r = dv_complete ? stub_r : 32'hBAAD_F00D;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge div_clk);
        #1;
    endtask

    // Reference: quotient truncated toward zero, remainder takes dividend sign.
    task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        longint na, nb, nq, nr;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else begin
            if (sgn) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            nq = na / nb;
            nr = na - nq * nb;
            q  = nq[31:0];
            r  = nr[31:0];
        end
    endtask

    // Full divide from accept through the cycle after complete. Operands and
    // sign on the EX side are scrambled after accept to prove they are latched.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        int  stall_cnt;
        bit  done;
        model_div(sgn, a, b, q, r);
        ex_div_signed = sgn;
        ex_src_a      = a;
        ex_src_b      = b;
        ex_div_valid  = 1'b1;
        #1;
        stall_cnt = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (stall) stall_cnt++;
            if (dv_complete) begin
                done = 1'b1;
                check("dv_x_held", dv_x, a);
                check("dv_y_held", dv_y, b);
                check("stall_on_complete", {31'd0, stall}, 32'd0);
                check("lo_bypass_complete", lo_rdata, q);
                check("hi_bypass_complete", hi_rdata, r);
                ex_div_valid = 1'b0;
            end else begin
                tick();
                if (cyc == 0) begin
                    ex_src_a      = ~a;
                    ex_src_b      = $urandom;
                    ex_div_signed = ~sgn;
                end
                #1;
            end
        end
        check("div_completed", {31'd0, done}, 32'd1);
        check("stall_cycles", stall_cnt, 32'd34);
        tick();
        check("dv_div_low_after", {31'd0, dv_div}, 32'd0);
        check("busy_after", {31'd0, div_busy}, 32'd0);
        check("lo_written", lo_rdata, q);
        check("hi_written", hi_rdata, r);
        exp_lo = q;
        exp_hi = r;
    endtask

    initial begin
        bit          seen;
        int          run_cyc;
        logic [31:0] a, b, d;
        bit          sgn;

        // ---- reset ----
        repeat (3) tick();
        check("rst_hi", hi_rdata, 32'd0);
        check("rst_lo", lo_rdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_err", {31'd0, div_err}, 32'd0);
        check("rst_dv_div", {31'd0, dv_div}, 32'd0);
        check("rst_choke", {31'd0, dv_choke}, 32'd0);
        check("rst_dv_x", dv_x, 32'd0);
        resetn = 1'b1;
        tick();

        // ---- DIVU 100/7 ----
        run_div(1'b0, 32'd100, 32'd7);
        check("divu_100_7_lo", lo_rdata, 32'd14);
        check("divu_100_7_hi", hi_rdata, 32'd2);

        // ---- DIV -7/2 ----
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_lo", lo_rdata, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi_rdata, 32'hFFFF_FFFF);

        // ---- flush at RUN cycle 10 ----
        ex_div_signed = 1'b0; ex_src_a = 32'd1000; ex_src_b = 32'd3; ex_div_valid = 1'b1;
        #1;
        check("accept_stall", {31'd0, stall}, 32'd1);
        tick();
        repeat (10) tick();
        ex_flush = 1'b1;
        #1;
        check("flush_cycle_stall", {31'd0, stall}, 32'd1);
        tick();
        ex_flush = 1'b0; ex_div_valid = 1'b0;
        #1;
        check("flush_choke", {31'd0, dv_choke}, 32'd1);
        check("flush_dv_div", {31'd0, dv_div}, 32'd0);
        check("flush_abort_stall", {31'd0, stall}, 32'd1);
        check("flush_no_err", {31'd0, div_err}, 32'd0);
        tick();
        check("flush_choke_1cyc", {31'd0, dv_choke}, 32'd0);
        check("flush_idle", {31'd0, div_busy}, 32'd0);
        check("flush_hi_kept", hi_rdata, exp_hi);
        check("flush_lo_kept", lo_rdata, exp_lo);

        // ---- DIVU 9/3 ----
        run_div(1'b0, 32'd9, 32'd3);
        check("divu_9_3_lo", lo_rdata, 32'd3);
        check("divu_9_3_hi", hi_rdata, 32'd0);

        // ---- flush and complete in the same cycle ----
        ex_div_signed = 1'b0; ex_src_a = 32'd77; ex_src_b = 32'd5; ex_div_valid = 1'b1;
        #1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (dv_complete) seen = 1'b1;
            else tick();
        end
        check("fc_complete_seen", {31'd0, seen}, 32'd1);
        ex_flush = 1'b1;
        #1;
        tick();
        ex_flush = 1'b0; ex_div_valid = 1'b0;
        #1;
        check("fc_choke", {31'd0, dv_choke}, 32'd1);
        tick();
        check("fc_hi_kept", hi_rdata, exp_hi);
        check("fc_lo_kept", lo_rdata, exp_lo);
        check("fc_idle", {31'd0, div_busy}, 32'd0);

        // ---- timeout with a divider that never completes ----
        stub_en = 1'b0;
        ex_div_signed = 1'b1; ex_src_a = 32'd50; ex_src_b = 32'd6; ex_div_valid = 1'b1;
        #1;
        tick();
        seen = 1'b0;
        run_cyc = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (div_err) seen = 1'b1;
            else begin
                if (dv_div) run_cyc++;
                tick();
            end
        end
        check("to_err_seen", {31'd0, seen}, 32'd1);
        check("to_run_cycles", run_cyc, 32'd40);
        check("to_choke_with_err", {31'd0, dv_choke}, 32'd1);
        check("to_dv_div_low", {31'd0, dv_div}, 32'd0);
        ex_div_valid = 1'b0;
        tick();
        check("to_err_pulse", {31'd0, div_err}, 32'd0);
        check("to_idle", {31'd0, div_busy}, 32'd0);
        check("to_hi_kept", hi_rdata, exp_hi);
        check("to_lo_kept", lo_rdata, exp_lo);
        stub_en = 1'b1;

        // ---- MTLO / MTHI with same-cycle read ----
        mtlo_we = 1'b1; mt_data = 32'h0000_1234;
        #1;
        check("mtlo_bypass", lo_rdata, 32'h0000_1234);
        check("mtlo_hi_untouched", hi_rdata, exp_hi);
        tick();
        exp_lo = 32'h0000_1234;
        mtlo_we = 1'b0; d = $urandom; mthi_we = 1'b1; mt_data = d;
        #1;
        check("mthi_bypass", hi_rdata, d);
        check("mtlo_stored", lo_rdata, exp_lo);
        tick();
        exp_hi = d;
        mthi_we = 1'b0;
        #1;
        check("mthi_stored", hi_rdata, exp_hi);

        // ---- MTHI ignored while busy ----
        ex_src_a = 32'd8; ex_src_b = 32'd2; ex_div_valid = 1'b1;
        #1;
        tick();
        mthi_we = 1'b1; mt_data = ~exp_hi;
        #1;
        check("mthi_busy_no_bypass", hi_rdata, exp_hi);
        tick();
        mthi_we = 1'b0;
        #1;
        check("mthi_busy_no_write", hi_rdata, exp_hi);
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0; ex_div_valid = 1'b0;
        tick();
        check("mthi_busy_hi_final", hi_rdata, exp_hi);

        // ---- divide by zero still releases ----
        run_div(1'b0, 32'd12345, 32'd0);

        // ---- random divides with interleaved MTLO ----
        for (int n = 0; n < 6; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = (n % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            d = $urandom;
            mtlo_we = 1'b1; mt_data = d;
            tick();
            mtlo_we = 1'b0;
            exp_lo = d;
            #1;
            check("rand_mtlo", lo_rdata, exp_lo);
            run_div(sgn, a, b);
        end

        // ---- reset mid-divide ----
        ex_src_a = 32'd1000; ex_src_b = 32'd9; ex_div_valid = 1'b1;
        #1;
        tick();
        repeat (5) tick();
        resetn = 1'b0; ex_div_valid = 1'b0;
        tick();
        check("mid_rst_busy", {31'd0, div_busy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_dv_div", {31'd0, dv_div}, 32'd0);
        check("mid_rst_hi", hi_rdata, 32'd0);
        check("mid_rst_lo", lo_rdata, 32'd0);
        resetn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
